// File: rtl/adc_capture_pkg.sv
// Shared state encoding and default frame geometry for the ADC capture engine.
package adc_capture_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    QUIET = 3'd3,
    WRITE = 3'd4
  } state_e;

  localparam int DEF_CLK_DIV      = 2;
  localparam int DEF_FRAME_BITS   = 16;
  localparam int DEF_DATA_BITS    = 12;
  localparam int DEF_QUIET_HALVES = 2;
endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period tick generator: one-cycle tick every CLK_DIV cycles while enabled.
module sclk_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic CLK50,
  input  logic RESET,
  input  logic en,
  output logic tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CW'(CLK_DIV - 1));

  // Holding at zero while disabled keeps every phase aligned to a fresh count.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en || tick) cnt_d = '0;
  end

  always_ff @(posedge CLK50) begin
    if (RESET) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/adc_capture_ctrl.sv
// SPI-master capture of one serial ADC frame per start pulse, written to the sample FIFO.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int FRAME_BITS   = DEF_FRAME_BITS,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int QUIET_HALVES = DEF_QUIET_HALVES
) (
  input  logic                 CLK50,
  input  logic                 RESET,
  input  logic                 start,
  input  logic                 clear_overrun,
  input  logic                 MISO,
  input  logic                 fifo_full,
  output logic                 CS,
  output logic                 SCLK,
  output logic [DATA_BITS-1:0] fifo_wdata,
  output logic                 fifo_wren,
  output logic                 busy,
  output logic                 conv_complete,
  output logic                 overrun
);
  localparam int HMAX = (2 * FRAME_BITS > QUIET_HALVES) ? 2 * FRAME_BITS : QUIET_HALVES;
  localparam int HW   = $clog2(HMAX) + 1;

  state_e                  state_q, state_d;
  logic                    cs_q, cs_d, sclk_q, sclk_d, busy_q, busy_d;
  logic                    wren_q, wren_d, cc_q, cc_d, ovr_q, ovr_d;
  logic [DATA_BITS-1:0]    wdata_q, wdata_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [HW-1:0]           hcnt_q, hcnt_d;
  logic                    tick, tick_en;

  assign tick_en = (state_q == SETUP) || (state_q == SHIFT) || (state_q == QUIET);

  sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .CLK50 (CLK50),
    .RESET (RESET),
    .en    (tick_en),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    busy_d  = busy_q;
    wdata_d = wdata_q;
    shift_d = shift_q;
    hcnt_d  = hcnt_q;
    wren_d  = 1'b0;
    cc_d    = 1'b0;
    ovr_d   = clear_overrun ? 1'b0 : ovr_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETUP;
        cs_d    = 1'b0;
        busy_d  = 1'b1;
        hcnt_d  = '0;
        shift_d = '0;
      end
      SETUP: if (tick) begin
        state_d = SHIFT;
        sclk_d  = 1'b0;
      end
      SHIFT: if (tick) begin
        // A tick while low is the rising edge: the ADC data is stable here.
        if (!sclk_q) shift_d = {shift_q[FRAME_BITS-2:0], MISO};
        sclk_d = ~sclk_q;
        hcnt_d = hcnt_q + 1'b1;
        if (hcnt_q == HW'(2 * FRAME_BITS - 1)) begin
          state_d = QUIET;
          cs_d    = 1'b1;
          sclk_d  = 1'b1;
          hcnt_d  = '0;
        end
      end
      QUIET: if (tick) begin
        hcnt_d = hcnt_q + 1'b1;
        if (hcnt_q == HW'(QUIET_HALVES - 1)) begin
          state_d = WRITE;
          hcnt_d  = '0;
          cc_d    = 1'b1;
          if (!fifo_full) begin
            wren_d  = 1'b1;
            wdata_d = shift_q[DATA_BITS-1:0];
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK50) begin
    if (RESET) begin
      state_q <= IDLE;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      busy_q  <= 1'b0;
      wren_q  <= 1'b0;
      cc_q    <= 1'b0;
      ovr_q   <= 1'b0;
      wdata_q <= '0;
      shift_q <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      wren_q  <= wren_d;
      cc_q    <= cc_d;
      ovr_q   <= ovr_d;
      wdata_q <= wdata_d;
      shift_q <= shift_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign CS            = cs_q;
  assign SCLK          = sclk_q;
  assign busy          = busy_q;
  assign fifo_wren     = wren_q;
  assign fifo_wdata    = wdata_q;
  assign conv_complete = cc_q;
  assign overrun       = ovr_q;
endmodule
